clk_div_frac: RTL and testbench

CLK_DIV_FRAC -- requirements
Module: clk_div_frac

---
 rtl/clk_div_frac.sv | 127 ++++++++++++
 tb/tb_clk_div_frac.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_frac.sv
// Fractional clock divider: output period alternates between N and N+1 clk cycles
// so that the long-run average period is N + F/2^FRAC_W.
module clk_div_frac #(
   parameter int INT_W    = 8,
   parameter int FRAC_W   = 8,
   parameter int DEF_INT  = 2,
   parameter int DEF_FRAC = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              load,
   input  logic [INT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              clk_div,
   output logic              tick,
   output logic              busy
);

   localparam logic [INT_W-1:0]  TWO_I      = INT_W'(2);
   localparam logic [INT_W-1:0]  DEF_INT_C  = (DEF_INT < 2) ? TWO_I : INT_W'(DEF_INT);
   localparam logic [FRAC_W-1:0] DEF_FRAC_C = FRAC_W'(DEF_FRAC);
   localparam logic [INT_W:0]    ONE_D      = (INT_W+1)'(1);

   // Divisors below 2 cannot produce a high and a low phase, so they become 2.
   function automatic logic [INT_W-1:0] clamp_int(input logic [INT_W-1:0] v);
      return (v < TWO_I) ? TWO_I : v;
   endfunction

   logic              run_q, run_d;
   logic [INT_W:0]    cnt_q, cnt_d;
   logic [INT_W:0]    d_q, d_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [INT_W-1:0]  a_int_q, a_int_d;
   logic [FRAC_W-1:0] a_frac_q, a_frac_d;
   logic [INT_W-1:0]  sh_int_q, sh_int_d;
   logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
   logic              busy_q, busy_d;
   logic              clk_div_q, clk_div_d;
   logic              tick_q, tick_d;

   logic              last;
   logic              boundary;
   logic [INT_W-1:0]  eff_int;
   logic [FRAC_W-1:0] eff_frac;
   logic [FRAC_W:0]   sum;

   always_comb begin
      run_d     = run_q;
      cnt_d     = cnt_q;
      d_d       = d_q;
      acc_d     = acc_q;
      a_int_d   = a_int_q;
      a_frac_d  = a_frac_q;
      sh_int_d  = sh_int_q;
      sh_frac_d = sh_frac_q;
      busy_d    = busy_q;
      tick_d    = 1'b0;

      last     = (cnt_q == (d_q - ONE_D));
      boundary = en && (!run_q || last);
      // A pending shadow takes effect in the same period it is promoted.
      eff_int  = busy_q ? sh_int_q  : a_int_q;
      eff_frac = busy_q ? sh_frac_q : a_frac_q;
      sum      = {1'b0, acc_q} + {1'b0, eff_frac};

      if (boundary) begin
         run_d    = 1'b1;
         a_int_d  = eff_int;
         a_frac_d = eff_frac;
         busy_d   = 1'b0;
         acc_d    = sum[FRAC_W-1:0];
         d_d      = {1'b0, eff_int} + (INT_W+1)'(sum[FRAC_W]);
         cnt_d    = '0;
         tick_d   = 1'b1;
      end else if (run_q) begin
         if (last) begin
            // Period finished with en low: park, holding CNT and ACC.
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q + ONE_D;
         end
      end

      // Applied after the boundary update so a load in a boundary cycle stays pending.
      if (load) begin
         sh_int_d  = clamp_int(div_int);
         sh_frac_d = div_frac;
         busy_d    = 1'b1;
      end

      clk_div_d = run_d && (cnt_d < (d_d >> 1));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_q     <= 1'b0;
         cnt_q     <= '0;
         d_q       <= {1'b0, DEF_INT_C};
         acc_q     <= '0;
         a_int_q   <= DEF_INT_C;
         a_frac_q  <= DEF_FRAC_C;
         sh_int_q  <= DEF_INT_C;
         sh_frac_q <= DEF_FRAC_C;
         busy_q    <= 1'b0;
         clk_div_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         run_q     <= run_d;
         cnt_q     <= cnt_d;
         d_q       <= d_d;
         acc_q     <= acc_d;
         a_int_q   <= a_int_d;
         a_frac_q  <= a_frac_d;
         sh_int_q  <= sh_int_d;
         sh_frac_q <= sh_frac_d;
         busy_q    <= busy_d;
         clk_div_q <= clk_div_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_div = clk_div_q;
   assign tick    = tick_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_clk_div_frac.sv
// Directed bench for clk_div_frac: a wide-fraction instance (FRAC_W=8) and a
// FRAC_W=2 instance with an out-of-range DEF_INT.
module tb_clk_div_frac;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       en_a = 1'b0, load_a = 1'b0;
   logic [7:0] di_a = '0, df_a = '0;
   logic       clk_div_a, tick_a, busy_a;
   logic       en_b = 1'b0, load_b = 1'b0;
   logic [7:0] di_b = '0;
   logic [1:0] df_b = '0;
   logic       clk_div_b, tick_b, busy_b;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   clk_div_frac #(.INT_W(8), .FRAC_W(8), .DEF_INT(2), .DEF_FRAC(0)) dut_a (
      .clk(clk), .rstn(rstn), .en(en_a), .load(load_a), .div_int(di_a), .div_frac(df_a),
      .clk_div(clk_div_a), .tick(tick_a), .busy(busy_a));

   clk_div_frac #(.INT_W(8), .FRAC_W(2), .DEF_INT(1), .DEF_FRAC(0)) dut_b (
      .clk(clk), .rstn(rstn), .en(en_b), .load(load_b), .div_int(di_b), .div_frac(df_b),
      .clk_div(clk_div_b), .tick(tick_b), .busy(busy_b));

   typedef struct {
      bit sel;
      int n;
      int f;
      int l0, l1, l2, l3;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input int act, input int exp);
      ntests++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int g_clk(input bit sel);
      return sel ? int'(clk_div_b) : int'(clk_div_a);
   endfunction
   function automatic int g_tick(input bit sel);
      return sel ? int'(tick_b) : int'(tick_a);
   endfunction
   function automatic int g_busy(input bit sel);
      return sel ? int'(busy_b) : int'(busy_a);
   endfunction

   task automatic set_en(input bit sel, input logic v);
      if (sel) en_b = v;
      else     en_a = v;
   endtask

   task automatic do_load(input bit sel, input int n, input int f);
      @(negedge clk);
      if (sel) begin load_b = 1'b1; di_b = 8'(n); df_b = 2'(f); end
      else     begin load_a = 1'b1; di_a = 8'(n); df_a = 8'(f); end
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rstn   = 1'b0;
      en_a   = 1'b0; en_b   = 1'b0;
      load_a = 1'b0; load_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Counts negedges until the next tick sample.
   task automatic wait_tick(input bit sel, output int n);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         n++;
         if (g_tick(sel) != 0) return;
      end
      chk("wait_tick_timeout", 0, 1);
   endtask

   // Called on a tick sample; returns the length and high time of that period.
   task automatic measure(input bit sel, output int len, output int hi);
      len = 1;
      hi  = g_clk(sel);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (g_tick(sel) != 0) return;
         len++;
         hi += g_clk(sel);
      end
      chk("measure_timeout", 0, 1);
   endtask

   initial begin
      int n, len, hi, ticks;
      int exp_l[4];

      vecs[0]  = '{1'b0,   2,   0,   2,   2,   2,   2};
      vecs[1]  = '{1'b0,   4,   0,   4,   4,   4,   4};
      vecs[2]  = '{1'b0,   3,   0,   3,   3,   3,   3};
      vecs[3]  = '{1'b0,   6,   0,   6,   6,   6,   6};
      vecs[4]  = '{1'b0,   0,   0,   2,   2,   2,   2};
      vecs[5]  = '{1'b0,   1,   0,   2,   2,   2,   2};
      vecs[6]  = '{1'b0,   4,  64,   4,   4,   4,   5};
      vecs[7]  = '{1'b0,   4, 128,   4,   5,   4,   5};
      vecs[8]  = '{1'b0, 255, 255, 255, 256, 256, 256};
      vecs[9]  = '{1'b0,   7,   1,   7,   7,   7,   7};
      vecs[10] = '{1'b1,   4,   2,   4,   5,   4,   5};
      vecs[11] = '{1'b1,   4,   1,   4,   4,   4,   5};
      vecs[12] = '{1'b1,   5,   3,   5,   6,   6,   6};
      vecs[13] = '{1'b1,   0,   3,   2,   3,   3,   3};

      // Reset state
      #12;
      chk("rst_clk_div_a", int'(clk_div_a), 0);
      chk("rst_tick_a",    int'(tick_a),    0);
      chk("rst_busy_a",    int'(busy_a),    0);
      chk("rst_clk_div_b", int'(clk_div_b), 0);

      // Defaults after reset: divide by 2
      apply_reset();
      en_a = 1'b1;
      en_b = 1'b1;
      wait_tick(1'b0, n);
      chk("def_first_latency", n, 1);
      chk("def_busy", int'(busy_a), 0);
      @(negedge clk);
      chk("def_clk_low", int'(clk_div_a), 0);
      chk("def_tick_low", int'(tick_a), 0);
      @(negedge clk);
      chk("def_clk_high", int'(clk_div_a), 1);
      chk("def_tick_high", int'(tick_a), 1);
      measure(1'b0, len, hi);
      chk("def_len_a", len, 2);
      chk("def_hi_a", hi, 1);
      measure(1'b1, len, hi);
      chk("def_len_b_clamped", len, 2);

      // Table: reset, idle loads (last wins), enable, check four periods
      foreach (vecs[r]) begin
         apply_reset();
         do_load(vecs[r].sel, 5, 0);
         do_load(vecs[r].sel, vecs[r].n, vecs[r].f);
         chk($sformatf("row%0d_busy_idle", r), g_busy(vecs[r].sel), 1);
         @(negedge clk);
         set_en(vecs[r].sel, 1'b1);
         @(negedge clk);
         chk($sformatf("row%0d_first_high", r), g_clk(vecs[r].sel), 1);
         chk($sformatf("row%0d_first_tick", r), g_tick(vecs[r].sel), 1);
         chk($sformatf("row%0d_busy_applied", r), g_busy(vecs[r].sel), 0);
         exp_l = '{vecs[r].l0, vecs[r].l1, vecs[r].l2, vecs[r].l3};
         for (int k = 0; k < 4; k++) begin
            measure(vecs[r].sel, len, hi);
            chk($sformatf("row%0d_len%0d", r, k), len, exp_l[k]);
            chk($sformatf("row%0d_hi%0d", r, k), hi, exp_l[k] / 2);
         end
         set_en(vecs[r].sel, 1'b0);
      end

      // Two loads mid-period: second wins at the boundary; load in a boundary cycle waits a period
      apply_reset();
      do_load(1'b0, 6, 0);
      en_a = 1'b1;
      wait_tick(1'b0, n);
      load_a = 1'b1; di_a = 8'd5; df_a = 8'd0;
      @(negedge clk);
      di_a = 8'd3;
      @(negedge clk);
      load_a = 1'b0;
      chk("ovr_busy_pending", int'(busy_a), 1);
      wait_tick(1'b0, n);
      chk("ovr_old_period_rest", n, 4);
      chk("ovr_busy_cleared", int'(busy_a), 0);
      measure(1'b0, len, hi);
      chk("ovr_len_second_load", len, 3);
      chk("ovr_hi_second_load", hi, 1);
      @(negedge clk);
      @(negedge clk);
      load_a = 1'b1; di_a = 8'd4;
      @(negedge clk);
      load_a = 1'b0;
      chk("bnd_tick", int'(tick_a), 1);
      chk("bnd_busy_still", int'(busy_a), 1);
      measure(1'b0, len, hi);
      chk("bnd_len_not_yet", len, 3);
      chk("bnd_busy_after", int'(busy_a), 0);
      measure(1'b0, len, hi);
      chk("bnd_len_applied", len, 4);
      chk("bnd_hi_applied", hi, 2);

      // en dropped mid-period: period completes, output parks low, ACC held
      apply_reset();
      do_load(1'b0, 6, 128);
      en_a = 1'b1;
      wait_tick(1'b0, n);
      hi = int'(clk_div_a);
      ticks = 0;
      @(negedge clk);
      en_a = 1'b0;
      hi += int'(clk_div_a);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         hi    += int'(clk_div_a);
         ticks += int'(tick_a);
      end
      chk("endrop_hi_total", hi, 3);
      chk("endrop_no_tick", ticks, 0);
      chk("endrop_parked_low", int'(clk_div_a), 0);
      en_a = 1'b1;
      @(negedge clk);
      chk("enrise_clk_high", int'(clk_div_a), 1);
      chk("enrise_tick", int'(tick_a), 1);
      measure(1'b0, len, hi);
      chk("enrise_len_acc_carry", len, 7);
      measure(1'b0, len, hi);
      chk("enrise_len_next", len, 6);

      // Reset mid-period with a pending load
      apply_reset();
      do_load(1'b0, 6, 0);
      en_a = 1'b1;
      wait_tick(1'b0, n);
      load_a = 1'b1; di_a = 8'd9;
      @(negedge clk);
      load_a = 1'b0;
      chk("mrst_pre_clk", int'(clk_div_a), 1);
      chk("mrst_pre_busy", int'(busy_a), 1);
      #1 rstn = 1'b0;
      #1;
      chk("mrst_clk_div", int'(clk_div_a), 0);
      chk("mrst_tick", int'(tick_a), 0);
      chk("mrst_busy", int'(busy_a), 0);
      @(negedge clk);
      rstn = 1'b1;
      wait_tick(1'b0, n);
      chk("mrst_first_latency", n, 1);
      measure(1'b0, len, hi);
      chk("mrst_len_default", len, 2);
      do_load(1'b0, 5, 0);
      for (int i = 0; i < 10; i++) begin
         wait_tick(1'b0, n);
         if (!busy_a) break;
      end
      measure(1'b0, len, hi);
      chk("mrst_len_five", len, 5);
      do_load(1'b0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         wait_tick(1'b0, n);
         if (!busy_a) break;
      end
      measure(1'b0, len, hi);
      chk("mrst_len_zero_clamped", len, 2);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
